dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs. DMA, zero-wait grants, locked DMA bursts.
// Optional DMA anti-starvation counter enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic              dma_lock_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StCpu, StDma, StDmaLock} state_e;

  state_e state_q, state_d;
  logic   cpu_gnt, dma_gnt, force_dma;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (dma_gnt) begin
      starve_d = 8'd0;
    end else if (dma_req_i && !rst_i && (starve_q != Limit)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_dma = dma_req_i && (starve_q == Limit);
`else
  assign force_dma = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decision; reset masks every grant so all outputs fall to 0 immediately.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst_i) begin
      if ((state_q == StDmaLock) && dma_req_i && dma_lock_i) begin
        dma_gnt = 1'b1;
      end else if (force_dma) begin
        dma_gnt = 1'b1;
      end else if (cpu_req_i) begin
        cpu_gnt = 1'b1;
      end else if (dma_req_i) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = StIdle;
    if (cpu_gnt) begin
      state_d = StCpu;
    end else if (dma_gnt) begin
      state_d = dma_lock_i ? StDmaLock : StDma;
    end
  end

  always_comb begin
    cpu_ack_o   = cpu_gnt;
    dma_ack_o   = dma_gnt;
    cpu_stall_o = cpu_req_i && !cpu_gnt && !rst_i;
    cpu_rdata_o = '0;
    dma_rdata_o = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt) begin
      mem_rd_o    = !cpu_we_i;
      mem_wr_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      if (!cpu_we_i) begin
        cpu_rdata_o = mem_rdata_i;
      end
    end else if (dma_gnt) begin
      mem_rd_o    = !dma_we_i;
      mem_wr_o    = dma_we_i;
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
      if (!dma_we_i) begin
        dma_rdata_o = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; expectations follow the
// DMEM_ARB_STARVE_EN setting of the build.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o  (cpu_ack),
    .cpu_stall_o(cpu_stall),
    .cpu_rdata_o(cpu_rdata),
    .dma_req_i  (dma_req),
    .dma_we_i   (dma_we),
    .dma_lock_i (dma_lock),
    .dma_addr_i (dma_addr),
    .dma_wdata_i(dma_wdata),
    .dma_ack_o  (dma_ack),
    .dma_rdata_o(dma_rdata),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0;
  endtask

  initial begin
    logic exp_dma;
    rst = 1;
    idle_inputs();
    cpu_req = 1; dma_req = 1; dma_we = 1; mem_rdata = 32'hdead;
    #2;
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 0);
    chk("rst_dma_ack", {31'd0, dma_ack}, 0);
    chk("rst_stall", {31'd0, cpu_stall}, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    next();
    rst = 0;
    idle_inputs();

    // No requests: memory side idle
    next(); #1;
    chk("idle_mem_rd", {31'd0, mem_rd}, 0);
    chk("idle_mem_addr", mem_addr, 0);

    // CPU read, zero-wait
    next();
    cpu_req = 1; cpu_addr = 32'h10; mem_rdata = 32'h1234;
    #1;
    chk("rd_mem_rd", {31'd0, mem_rd}, 1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_cpu_ack", {31'd0, cpu_ack}, 1);
    chk("rd_cpu_rdata", cpu_rdata, 32'h1234);
    chk("rd_stall", {31'd0, cpu_stall}, 0);
    chk("rd_dma_rdata", dma_rdata, 0);

    // Simultaneous writes to same address: CPU first, then DMA
    next();
    cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'haa;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hbb;
    #1;
    chk("ww_cpu_ack", {31'd0, cpu_ack}, 1);
    chk("ww_dma_ack", {31'd0, dma_ack}, 0);
    chk("ww_mem_wdata", mem_wdata, 32'haa);
    chk("ww_mem_wr", {31'd0, mem_wr}, 1);
    next();
    cpu_req = 0; cpu_we = 0;
    #1;
    chk("ww2_dma_ack", {31'd0, dma_ack}, 1);
    chk("ww2_mem_addr", mem_addr, 32'h20);
    chk("ww2_mem_wdata", mem_wdata, 32'hbb);
    chk("ww2_mem_wr", {31'd0, mem_wr}, 1);

    // Locked DMA read burst: entry cycle, then 4 cycles holding off a CPU request
    next();
    idle_inputs();
    dma_req = 1; dma_lock = 1; dma_addr = 32'h40; mem_rdata = 32'h55;
    #1;
    chk("lk0_dma_ack", {31'd0, dma_ack}, 1);
    chk("lk0_dma_rdata", dma_rdata, 32'h55);
    chk("lk0_cpu_rdata", cpu_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      next();
      cpu_req = 1; cpu_addr = 32'h10;
      #1;
      chk("lk_dma_ack", {31'd0, dma_ack}, 1);
      chk("lk_stall", {31'd0, cpu_stall}, 1);
      chk("lk_cpu_ack", {31'd0, cpu_ack}, 0);
    end
    next();
    dma_lock = 0;
    #1;
    chk("lk5_cpu_ack", {31'd0, cpu_ack}, 1);
    chk("lk5_dma_ack", {31'd0, dma_ack}, 0);
    chk("lk5_stall", {31'd0, cpu_stall}, 0);

    // Reset during a locked DMA write burst
    next();
    idle_inputs();
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h77;
    #1;
    chk("rl0_dma_ack", {31'd0, dma_ack}, 1);
    next();
    cpu_req = 1; cpu_addr = 32'h14;
    #1;
    chk("rl1_dma_ack", {31'd0, dma_ack}, 1);
    chk("rl1_stall", {31'd0, cpu_stall}, 1);
    rst = 1;
    #1;
    chk("rl_rst_dma_ack", {31'd0, dma_ack}, 0);
    chk("rl_rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rl_rst_mem_addr", mem_addr, 0);
    chk("rl_rst_stall", {31'd0, cpu_stall}, 0);
    next();
    rst = 0;
    next(); #1;
    chk("rl_post_cpu_ack", {31'd0, cpu_ack}, 1);
    chk("rl_post_dma_ack", {31'd0, dma_ack}, 0);
    chk("rl_post_mem_wr", {31'd0, mem_wr}, 0);

    // Continuous contention from a clean reset
    rst = 1;
    next();
    idle_inputs();
    rst = 0;
    cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h30;
    for (int i = 1; i <= 18; i++) begin
      if (i > 1) next();
      #1;
`ifdef DMEM_ARB_STARVE_EN
      exp_dma = (i % 9 == 0);
`else
      exp_dma = 1'b0;
`endif
      chk("sv_dma_ack", {31'd0, dma_ack}, {31'd0, exp_dma});
      chk("sv_cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_dma});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
